// File: rtl/dma_pkg.sv
// dma_pkg: channel/scheduler encodings and register map for the DMA channel scheduler
package dma_pkg;
  typedef enum logic [2:0] {
    CH_IDLE    = 3'd0,
    CH_PENDING = 3'd1,
    CH_ACTIVE  = 3'd2,
    CH_DONE    = 3'd3,
    CH_ERROR   = 3'd4
  } ch_state_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} sched_state_e;
  localparam int CH_STRIDE = 'h20;
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_LEN    = 5'h04;
  localparam logic [4:0] OFF_SRC    = 5'h08;
  localparam logic [4:0] OFF_DST    = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam int ADDR_IRQ_STAT = 'h100;
  localparam int ADDR_IRQ_EN   = 'h104;
  localparam int CTRL_START    = 0;
endpackage

// File: rtl/dma_rr_arb.sv
// dma_rr_arb: picks the lowest pending channel index at or after the round-robin pointer
module dma_rr_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] gnt,
  output logic         vld
);
  logic [W:0] s;
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, rr_ptr} + (W+1)'(i);
      s = s >= (W+1)'(N) ? s - (W+1)'(N) : s;
      if (pend[s[W-1:0]]) begin
        gnt = s[W-1:0];
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_chan_sched.sv
// dma_chan_sched: register-programmed DMA channels feeding one engine through a round-robin scheduler
module dma_chan_sched
  import dma_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int REG_AW     = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_AW-1:0]     reg_addr_i,
  input  logic                  reg_write_i,
  input  logic                  reg_valid_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  output logic [DATA_WIDTH-1:0] reg_rdata_o,
  output logic                  reg_ready_o,
  output logic                  reg_error_o,
  output logic                  eng_req_o,
  output logic [ADDR_WIDTH-1:0] eng_src_o,
  output logic [ADDR_WIDTH-1:0] eng_dst_o,
  output logic [LEN_WIDTH-1:0]  eng_len_o,
  input  logic                  eng_ack_i,
  input  logic                  eng_done_i,
  input  logic                  eng_err_i,
  output logic                  irq_o
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SH = $clog2(CH_STRIDE);
  ch_state_e st [NUM_CH];
  logic [LEN_WIDTH-1:0] len [NUM_CH];
  logic [ADDR_WIDTH-1:0] src [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst [NUM_CH];
  logic [NUM_CH-1:0] irq_stat, irq_en, pend, set, clr;
  logic [CW-1:0] rr_ptr, gnt, arb_gnt, ci;
  logic [SH-1:0] off;
  logic arb_vld, ch_hit, g_stat, g_en, mapped, busy, rej, we;
  sched_state_e fsm;
  assign off = reg_addr_i[SH-1:0];
  assign ci = reg_addr_i[SH +: CW];
  assign ch_hit = (reg_addr_i >> SH) < REG_AW'(NUM_CH) &&
                  off inside {OFF_CTRL, OFF_LEN, OFF_SRC, OFF_DST, OFF_STATUS};
  assign g_stat = reg_addr_i == REG_AW'(ADDR_IRQ_STAT);
  assign g_en = reg_addr_i == REG_AW'(ADDR_IRQ_EN);
  assign mapped = ch_hit | g_stat | g_en;
  assign busy = st[ci] inside {CH_PENDING, CH_ACTIVE};
  assign rej = ch_hit & reg_write_i & (off == OFF_STATUS | busy);
  assign reg_error_o = reg_valid_i & (~mapped | rej);
  assign we = reg_valid_i & reg_write_i & mapped & ~rej;
  assign clr = we && g_stat ? reg_wdata_i[NUM_CH-1:0] : '0;
  assign reg_ready_o = 1'b1;
  assign reg_rdata_o = g_stat ? DATA_WIDTH'(irq_stat) :
                       g_en   ? DATA_WIDTH'(irq_en) :
                       !ch_hit ? '0 :
                       off == OFF_LEN    ? DATA_WIDTH'(len[ci]) :
                       off == OFF_SRC    ? DATA_WIDTH'(src[ci]) :
                       off == OFF_DST    ? DATA_WIDTH'(dst[ci]) :
                       off == OFF_STATUS ? DATA_WIDTH'(st[ci]) : '0;
  // zero-length starts never reach the arbiter; they complete on their own
  always_comb begin
    pend = '0;
    set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pend[i] = st[i] == CH_PENDING && len[i] != '0;
      set[i] = st[i] == CH_PENDING && len[i] == '0;
    end
    if (fsm == S_BUSY && eng_done_i) set[gnt] = 1'b1;
  end
  dma_rr_arb #(.N(NUM_CH), .W(CW)) u_arb (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .vld    (arb_vld)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] <= CH_IDLE;
        len[i] <= '0;
        src[i] <= '0;
        dst[i] <= '0;
      end
      irq_stat <= '0;
      irq_en <= '0;
      irq_o <= 1'b0;
      rr_ptr <= '0;
      gnt <= '0;
      fsm <= S_IDLE;
      eng_req_o <= 1'b0;
      eng_src_o <= '0;
      eng_dst_o <= '0;
      eng_len_o <= '0;
    end else begin
      irq_o <= |(irq_stat & irq_en);
      irq_stat <= (irq_stat & ~clr) | set;
      if (we && g_en) irq_en <= reg_wdata_i[NUM_CH-1:0];
      if (we && ch_hit) begin
        if (off == OFF_LEN) len[ci] <= reg_wdata_i[LEN_WIDTH-1:0];
        if (off == OFF_SRC) src[ci] <= ADDR_WIDTH'(reg_wdata_i);
        if (off == OFF_DST) dst[ci] <= ADDR_WIDTH'(reg_wdata_i);
        if (off == OFF_CTRL && reg_wdata_i[CTRL_START]) st[ci] <= CH_PENDING;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (st[i] == CH_PENDING && len[i] == '0) st[i] <= CH_DONE;
      case (fsm)
        S_IDLE: if (arb_vld) begin
          gnt <= arb_gnt;
          eng_req_o <= 1'b1;
          eng_src_o <= src[arb_gnt];
          eng_dst_o <= dst[arb_gnt];
          eng_len_o <= len[arb_gnt];
          fsm <= S_REQ;
        end
        S_REQ: if (eng_ack_i) begin
          eng_req_o <= 1'b0;
          st[gnt] <= CH_ACTIVE;
          fsm <= S_BUSY;
        end
        S_BUSY: if (eng_done_i) begin
          st[gnt] <= eng_err_i ? CH_ERROR : CH_DONE;
          rr_ptr <= gnt == CW'(NUM_CH - 1) ? '0 : gnt + 1'b1;
          fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_chan_sched.sv
// tb_dma_chan_sched: directed register/engine sequences with hand-computed expectations
module tb_dma_chan_sched;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [11:0] reg_addr = '0;
  logic reg_write = 1'b0, reg_valid = 1'b0;
  logic [31:0] reg_wdata = '0, reg_rdata;
  logic reg_ready, reg_error;
  logic eng_req, eng_ack = 1'b0, eng_done = 1'b0, eng_err = 1'b0, irq;
  logic [31:0] eng_src, eng_dst;
  logic [7:0] eng_len;
  int checks = 0, errors = 0, req_cnt = 0, req_snap;
  dma_chan_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .reg_addr_i  (reg_addr),
    .reg_write_i (reg_write),
    .reg_valid_i (reg_valid),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .reg_ready_o (reg_ready),
    .reg_error_o (reg_error),
    .eng_req_o   (eng_req),
    .eng_src_o   (eng_src),
    .eng_dst_o   (eng_dst),
    .eng_len_o   (eng_len),
    .eng_ack_i   (eng_ack),
    .eng_done_i  (eng_done),
    .eng_err_i   (eng_err),
    .irq_o       (irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (eng_req) req_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d, input logic e);
    @(negedge clk);
    reg_addr = a;
    reg_wdata = d;
    reg_write = 1'b1;
    reg_valid = 1'b1;
    #1 chk({tag, " err"}, 32'(reg_error), 32'(e));
    @(posedge clk);
    #1 reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] x, input logic e);
    @(negedge clk);
    reg_addr = a;
    reg_write = 1'b0;
    reg_valid = 1'b1;
    #1 chk({tag, " data"}, reg_rdata, x);
    chk({tag, " err"}, 32'(reg_error), 32'(e));
    @(posedge clk);
    #1 reg_valid = 1'b0;
  endtask
  task automatic grant_ack(input string tag, input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
    for (int i = 0; i < 20 && !eng_req; i++) @(negedge clk);
    chk({tag, " req"}, 32'(eng_req), 1);
    chk({tag, " src"}, eng_src, s);
    chk({tag, " dst"}, eng_dst, d);
    chk({tag, " len"}, 32'(eng_len), 32'(l));
    repeat (2) @(negedge clk);
    chk({tag, " req held"}, {31'(eng_req), 1'b0} | 32'(eng_src == s), 3);
    eng_ack = 1'b1;
    @(posedge clk);
    #1 eng_ack = 1'b0;
  endtask
  task automatic done(input logic e);
    @(negedge clk);
    eng_done = 1'b1;
    eng_err = e;
    @(posedge clk);
    #1 eng_done = 1'b0;
    eng_err = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst req", 32'(eng_req), 0);
    chk("rst irq", 32'(irq), 0);
    chk("rst src", eng_src, 0);
    chk("ready", 32'(reg_ready), 1);
    rst_ni = 1'b1;
    rd("rst st0", 12'h010, 0, 0);
    rd("rst en", 12'h104, 0, 0);
    wr("en", 12'h104, 32'h1, 0);
    wr("len0", 12'h004, 16, 0);
    wr("src0", 12'h008, 32'h8000_0000, 0);
    wr("dst0", 12'h00C, 32'h8000_1000, 0);
    wr("go0", 12'h000, 1, 0);
    grant_ack("g0", 32'h8000_0000, 32'h8000_1000, 16);
    rd("st0 act", 12'h010, 2, 0);
    wr("src0 busy", 12'h008, 32'h1234, 1);
    rd("src0 kept", 12'h008, 32'h8000_0000, 0);
    rd("unmapped", 12'h0F0, 0, 1);
    rd("ctrl rd", 12'h000, 0, 0);
    done(1'b0);
    rd("st0 done", 12'h010, 3, 0);
    rd("istat0", 12'h100, 1, 0);
    chk("irq set", 32'(irq), 1);
    wr("w1c", 12'h100, 1, 0);
    rd("istat clr", 12'h100, 0, 0);
    chk("irq clr", 32'(irq), 0);
    wr("len1", 12'h024, 4, 0);
    wr("src1", 12'h028, 32'h1000_0100, 0);
    wr("dst1", 12'h02C, 32'h1000_0200, 0);
    wr("len3", 12'h064, 8, 0);
    wr("src3", 12'h068, 32'h3000_0300, 0);
    wr("dst3", 12'h06C, 32'h3000_0400, 0);
    wr("go1", 12'h020, 1, 0);
    grant_ack("g1", 32'h1000_0100, 32'h1000_0200, 4);
    wr("go3", 12'h060, 1, 0);
    wr("go0b", 12'h000, 1, 0);
    wr("go1 busy", 12'h020, 1, 1);
    done(1'b0);
    wr("go1b", 12'h020, 1, 0);
    grant_ack("rr3", 32'h3000_0300, 32'h3000_0400, 8);
    done(1'b0);
    grant_ack("rr0", 32'h8000_0000, 32'h8000_1000, 16);
    done(1'b0);
    grant_ack("rr1", 32'h1000_0100, 32'h1000_0200, 4);
    done(1'b0);
    rd("istat rr", 12'h100, 32'hB, 0);
    wr("clr all", 12'h100, 32'hF, 0);
    wr("len2 z", 12'h044, 0, 0);
    req_snap = req_cnt;
    wr("go2 z", 12'h040, 1, 0);
    repeat (3) @(negedge clk);
    chk("z noreq", 32'(req_cnt), 32'(req_snap));
    rd("st2 z", 12'h050, 3, 0);
    rd("istat z", 12'h100, 32'h4, 0);
    wr("len2", 12'h044, 5, 0);
    wr("src2", 12'h048, 32'h2000_0200, 0);
    wr("go2", 12'h040, 1, 0);
    grant_ack("g2", 32'h2000_0200, 32'h0, 5);
    done(1'b1);
    rd("st2 err", 12'h050, 4, 0);
    rd("istat err", 12'h100, 32'h4, 0);
    wr("clr2", 12'h100, 32'hF, 0);
    @(negedge clk);
    eng_done = 1'b1;
    eng_ack = 1'b1;
    @(posedge clk);
    #1 eng_done = 1'b0;
    eng_ack = 1'b0;
    rd("idle done", 12'h100, 0, 0);
    rd("st2 kept", 12'h050, 4, 0);
    chk("idle noreq", 32'(eng_req), 0);
    wr("go0c", 12'h000, 1, 0);
    grant_ack("gw", 32'h8000_0000, 32'h8000_1000, 16);
    @(negedge clk);
    reg_addr = 12'h100;
    reg_wdata = 32'h1;
    reg_write = 1'b1;
    reg_valid = 1'b1;
    eng_done = 1'b1;
    @(posedge clk);
    #1 reg_valid = 1'b0;
    reg_write = 1'b0;
    eng_done = 1'b0;
    rd("set wins", 12'h100, 1, 0);
    rd("st0 w", 12'h010, 3, 0);
    chk("irq w", 32'(irq), 1);
    wr("go3b", 12'h060, 1, 0);
    grant_ack("gr", 32'h3000_0300, 32'h3000_0400, 8);
    @(negedge clk);
    rst_ni = 1'b0;
    #1 chk("mid rst req", 32'(eng_req), 0);
    chk("mid rst src", eng_src, 0);
    chk("mid rst dst", eng_dst, 0);
    chk("mid rst len", 32'(eng_len), 0);
    chk("mid rst irq", 32'(irq), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    done(1'b0);
    rd("st3 rst", 12'h070, 0, 0);
    rd("istat rst", 12'h100, 0, 0);
    rd("src3 rst", 12'h068, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst noreq", 32'(eng_req), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_chan_sched.md
DMA_CHAN_SCHED -- requirements
Module: dma_chan_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (legal 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of the source and destination address registers.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of the register-bus data path.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, width of the transfer length field.
REQ-005 SHALL have parameter REG_AW, default 12, width of the register-bus address.
REQ-006 SHALL have one clock and an asynchronous active-low reset. The ports SHALL be named clk_i and rst_ni.
REQ-007 SHALL have the following ports, each given as name, direction, width, meaning:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- reg_addr_i  in  REG_AW  register-bus byte address
- reg_write_i  in  1  write strobe, qualified by reg_valid_i
- reg_valid_i  in  1  access valid
- reg_wdata_i  in  DATA_WIDTH  write data
- reg_rdata_o  out  DATA_WIDTH  read data, combinational
- reg_ready_o  out  1  always 1
- reg_error_o  out  1  error on unmapped or rejected access
- eng_req_o  out  1  transfer request to the DMA engine
- eng_src_o  out  ADDR_WIDTH  source address of the granted channel
- eng_dst_o  out  ADDR_WIDTH  destination address of the granted channel
- eng_len_o  out  LEN_WIDTH  length of the granted channel
- eng_ack_i  in  1  engine accepts the request
- eng_done_i  in  1  single-cycle pulse, transfer complete
- eng_err_i  in  1  qualifies eng_done_i as a failed transfer
- irq_o  out  1  level interrupt

Function
REQ-008 SHALL implement per-channel registers at base ch*0x20: CTRL 0x00, LEN 0x04, SRC 0x08, DST 0x0C, STATUS 0x10 (read-only).
REQ-009 SHALL implement global registers: IRQ_STAT at 0x100 (write-1-to-clear) and IRQ_EN at 0x104 (read/write, NUM_CH bits).
REQ-010 SHALL treat CTRL bit0 (START) as write-1: it moves an IDLE, DONE or ERROR channel to PENDING; CTRL SHALL read back as 0.
REQ-011 SHALL encode per-channel state in STATUS[2:0]: IDLE=0, PENDING=1, ACTIVE=2, DONE=3, ERROR=4.
REQ-012 SHALL reject writes to LEN, SRC, DST or CTRL of a PENDING or ACTIVE channel: register unchanged, reg_error_o=1 in the same cycle.
REQ-013 SHALL set reg_error_o=1 for any access to an unmapped address or to a channel index >= NUM_CH; reads of these return 0.
REQ-014 SHALL use a scheduler FSM with states S_IDLE, S_REQ and S_BUSY.
REQ-015 SHALL, in S_IDLE, grant the lowest PENDING channel index at or after rr_ptr (round-robin), latch the grant and go to S_REQ the next cycle.
REQ-016 SHALL, in S_REQ, hold eng_req_o=1 with stable eng_src_o, eng_dst_o and eng_len_o until eng_ack_i=1; on that cycle the channel goes to ACTIVE and the FSM goes to S_BUSY.
REQ-017 SHALL, in S_BUSY on eng_done_i, set the channel to DONE (or ERROR if eng_err_i=1), set its IRQ_STAT bit, set rr_ptr to grant+1 modulo NUM_CH, and return to S_IDLE.
REQ-018 SHALL complete a START with LEN=0 without an engine request: PENDING→DONE and IRQ_STAT set in the cycle after the write.
REQ-019 SHALL ignore eng_done_i outside S_BUSY and eng_ack_i outside S_REQ.
REQ-020 SHALL give priority to the set when an IRQ_STAT W1C clear coincides with a set of the same bit.
REQ-021 SHALL drive irq_o = |(IRQ_STAT & IRQ_EN), registered (one cycle after the status change).
REQ-022 SHALL have a throughput of at most one transfer grant per 3 cycles; no transfer shall be outstanding concurrently.

Reset
REQ-023 SHALL clear on reset, asynchronously: all registers, every channel to IDLE, FSM to S_IDLE, rr_ptr to 0, eng_req_o/eng_src_o/eng_dst_o/eng_len_o to 0, irq_o to 0.
REQ-024 SHALL abandon any in-flight transfer on reset mid-operation without reporting it; an eng_done_i after reset is ignored per REQ-019.

Structure
REQ-025 SHALL place the state encodings, FSM enum, register offsets, CTRL bit positions and channel stride in package dma_pkg.
REQ-026 SHALL implement the round-robin grant in sub-module dma_rr_arb (inputs: pending vector and rr_ptr; outputs: grant index and valid).

Verification
REQ-027 SHALL cover: ch0 with LEN=16, SRC=0x8000_0000, DST=0x8000_1000, START; ack after 2 cycles; done → eng_* values match, STATUS=3, IRQ_STAT=0x1, irq_o=1 with IRQ_EN=0x1.
REQ-028 SHALL cover: START on ch1 and ch3 in the same cycle with rr_ptr=2 → ch3 is granted first, then ch1.
REQ-029 SHALL cover: write to SRC of an ACTIVE channel → reg_error_o=1 and the register is unchanged; read of 0x0F0 → reg_error_o=1 and rdata=0.
REQ-030 SHALL cover: LEN=0 START → DONE with no eng_req_o pulse; done with eng_err_i=1 → STATUS=4.
REQ-031 SHALL cover: W1C of IRQ_STAT in the same cycle as a done on that channel → the bit stays 1.
REQ-032 SHALL cover: rst_ni asserted during S_BUSY → all outputs 0 immediately; a later eng_done_i changes nothing.
